// File: rtl/aer_pkg.sv
// Shared constants and event record for the AER spike encoder.
package aer_pkg;

    localparam int NUM_NEURONS = 8;
    localparam int ADDR_W      = 3;
    localparam int TS_MAX_W    = 32;

    // "time" is a reserved word, so the timestamp field is ev_time; it is sized for the widest supported TS_WIDTH.
    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [TS_MAX_W-1:0] ev_time;
    } aer_event_t;

endpackage

// File: rtl/aer_fifo.sv
// Synchronous event FIFO whose head-of-queue entry is held in a dedicated output register.
module aer_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [DATA_W-1:0]            i_data,
    input  logic                         i_pop,
    output logic [DATA_W-1:0]            o_data,
    output logic                         o_empty,
    output logic                         o_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_head;

    logic              w_wr;
    logic              w_rd;
    logic [PTR_W-1:0]  w_rdPtrNext;
    logic [CNT_W-1:0]  w_countAfterPop;

    assign o_empty         = (r_count == '0);
    assign o_full          = (r_count == CNT_W'(DEPTH));
    assign o_count         = r_count;
    assign o_data          = r_head;
    assign w_wr            = i_push & ~o_full;
    assign w_rd            = i_pop & ~o_empty;
    assign w_rdPtrNext     = r_rdPtr + PTR_W'(w_rd);
    assign w_countAfterPop = r_count - CNT_W'(w_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= r_wrPtr + PTR_W'(1);
            end
            r_rdPtr <= w_rdPtrNext;
            r_count <= w_countAfterPop + CNT_W'(w_wr);
            // Head mirrors whatever sits at the read pointer after this edge; a push into an emptying queue bypasses memory.
            if (w_countAfterPop != '0) begin
                r_head <= r_mem[w_rdPtrNext];
            end else if (w_wr) begin
                r_head <= i_data;
            end else begin
                r_head <= '0;
            end
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Captures per-neuron spikes and serialises them round-robin into an AER event FIFO.
// Build macro AER_TIMESTAMP_EN adds a free-running timestamp captured per spike.
module spike_aer_encoder
    import aer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_NEURONS-1:0] spike,
    input  logic                   spike_valid,
    output logic                   event_valid,
    input  logic                   event_ready,
    output logic [ADDR_W-1:0]      event_addr,
    output logic [TS_WIDTH-1:0]    event_time,
    output logic                   fifo_full,
    output logic [7:0]             drop_cnt
);

`ifdef AER_TIMESTAMP_EN
    localparam int ENTRY_W = ADDR_W + TS_WIDTH;
`else
    localparam int ENTRY_W = ADDR_W;
`endif

    logic [NUM_NEURONS-1:0]            r_pending;
    logic [ADDR_W-1:0]                 r_rrPtr;
    logic [7:0]                        r_dropCnt;

    logic                              w_fifoEmpty;
    logic                              w_fifoFull;
    logic                              w_push;
    logic                              w_pop;
    logic                              w_found;
    logic [ADDR_W-1:0]                 w_sel;
    logic [NUM_NEURONS-1:0]            w_clear;
    logic [NUM_NEURONS-1:0]            w_spikeIn;
    logic [NUM_NEURONS-1:0]            w_collide;
    logic [ENTRY_W-1:0]                w_pushData;
    logic [ENTRY_W-1:0]                w_popData;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   w_fifoCount;
    aer_event_t                        w_popEvent;
    logic                              w_unused;

    // Circular priority search starting at the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            if (!w_found && r_pending[r_rrPtr + ADDR_W'(k)]) begin
                w_found = 1'b1;
                w_sel   = r_rrPtr + ADDR_W'(k);
            end
        end
    end

    assign w_push    = w_found & ~w_fifoFull;
    assign w_pop     = event_valid & event_ready;
    assign w_clear   = w_push ? (NUM_NEURONS'(1) << w_sel) : '0;
    assign w_spikeIn = spike_valid ? spike : '0;
    assign w_collide = w_spikeIn & r_pending & ~w_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_rrPtr   <= '0;
            r_dropCnt <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_spikeIn;
            if (w_push) begin
                r_rrPtr <= w_sel + ADDR_W'(1);
            end
            if ((|w_collide) && (r_dropCnt != 8'hFF)) begin
                r_dropCnt <= r_dropCnt + 8'd1;
            end
        end
    end

`ifdef AER_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]    r_timestamp;
    logic [TS_WIDTH-1:0]    r_ts [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] w_load;

    // A bit that collides keeps its original capture time.
    assign w_load = w_spikeIn & ~w_collide;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timestamp <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_ts[i] <= '0;
            end
        end else begin
            r_timestamp <= r_timestamp + TS_WIDTH'(1);
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (w_load[i]) begin
                    r_ts[i] <= r_timestamp;
                end
            end
        end
    end

    assign w_pushData = {w_sel, r_ts[w_sel]};
    assign w_popEvent = '{addr: w_popData[ENTRY_W-1 -: ADDR_W], ev_time: TS_MAX_W'(w_popData[TS_WIDTH-1:0])};
    assign event_time = w_popEvent.ev_time[TS_WIDTH-1:0];
`else
    assign w_pushData = w_sel;
    assign w_popEvent = '{addr: w_popData, ev_time: '0};
    assign event_time = '0;
`endif

    aer_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_pushData),
        .i_pop   (w_pop),
        .o_data  (w_popData),
        .o_empty (w_fifoEmpty),
        .o_full  (w_fifoFull),
        .o_count (w_fifoCount)
    );

    assign event_valid = ~w_fifoEmpty;
    assign event_addr  = w_popEvent.addr;
    assign fifo_full   = w_fifoFull;
    assign drop_cnt    = r_dropCnt;
    assign w_unused    = ^{w_popEvent, w_fifoCount};

endmodule
